// File: rtl/periodic_gap_inserter_pkg.sv
// rtl/periodic_gap_inserter_pkg.sv - shared states, register offsets and length clamp
package periodic_gap_inserter_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_GAP   = 2'd1,
        ST_FRAME = 2'd2
    } state_t;

    localparam logic [7:0] REG_FRAME_LEN  = 8'd0;
    localparam logic [7:0] REG_GAP_LEN    = 8'd1;
    localparam logic [7:0] REG_NO_GAP_SYM = 8'd2;

    function automatic logic [16:0] clamp_len(input logic [16:0] len, input logic [16:0] max_len);
        if (len == 17'd0)
            return 17'd1;
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage

// File: rtl/ram_2port.sv
// rtl/ram_2port.sv - simple dual-port RAM, write port A, registered read port B
module ram_2port #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 11
) (
    input  logic              clka,
    input  logic              ena,
    input  logic              wea,
    input  logic [AWIDTH-1:0] addra,
    input  logic [DWIDTH-1:0] dia,
    input  logic              clkb,
    input  logic              enb,
    input  logic [AWIDTH-1:0] addrb,
    output logic [DWIDTH-1:0] dob
);

    logic [DWIDTH-1:0] mem [2**AWIDTH];

    always_ff @(posedge clka) begin
        if (ena && wea)
            mem[addra] <= dia;
    end

    // dob only changes on enb, so it doubles as a stall-safe output register
    always_ff @(posedge clkb) begin
        if (enb)
            dob <= mem[addrb];
    end

endmodule

// File: rtl/setting_reg.sv
// rtl/setting_reg.sv - 16-bit settings-bus register
module setting_reg #(
    parameter logic [7:0] ADDR = 8'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        strobe,
    input  logic [7:0]  addr,
    input  logic [31:0] data_in,
    output logic [15:0] data_out
);

    logic unused_hi;
    assign unused_hi = ^data_in[31:16];

    always_ff @(posedge clk) begin
        if (reset)
            data_out <= 16'd0;
        else if (strobe && addr == ADDR)
            data_out <= data_in[15:0];
    end

endmodule

// File: rtl/periodic_gap_inserter.sv
// rtl/periodic_gap_inserter.sv - buffers one symbol and replays it with a cyclic-prefix gap
module periodic_gap_inserter #(
    parameter int BASE   = 0,
    parameter int WIDTH  = 32,
    parameter int AWIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [WIDTH-1:0] stream_i_tdata,
    input  logic             stream_i_tlast,
    input  logic             stream_i_tvalid,
    output logic             stream_i_tready,
    output logic [WIDTH-1:0] stream_o_tdata,
    output logic             stream_o_tlast,
    output logic             stream_o_tvalid,
    input  logic             stream_o_tready,
    output logic             eob
);
    import periodic_gap_inserter_pkg::*;

    localparam logic [16:0] MAX_LEN = 17'(2 ** AWIDTH);

    state_t state, state_next;
    logic [15:0] frame_len_reg, gap_len_reg, no_gap_reg;
    logic [AWIDTH-1:0] wr_addr, rd_addr;
    logic [AWIDTH-1:0] lat_fl_m1, lat_gap_start;
    logic              lat_gap_zero;
    logic [15:0]       lat_no_gap;
    logic [16:0] cfg_fl, cfg_gl, cfg_fl_m1, cfg_gap_start;
    logic [AWIDTH-1:0] eff_fl_m1, eff_gap_start;
    logic              eff_gap_zero;
    logic [15:0]       eff_no_gap;
    logic [15:0] sym_idx;
    logic        last_sym;
    logic        first_beat, in_fire, load_done, skip_gap, playing, advance, rd_end;
    logic        o_valid, o_last, o_eob;
    logic        unused_cfg;

    setting_reg #(.ADDR(8'(BASE + REG_FRAME_LEN))) u_frame_len (
        .clk(clk), .reset(reset), .strobe(set_stb), .addr(set_addr),
        .data_in(set_data), .data_out(frame_len_reg)
    );
    setting_reg #(.ADDR(8'(BASE + REG_GAP_LEN))) u_gap_len (
        .clk(clk), .reset(reset), .strobe(set_stb), .addr(set_addr),
        .data_in(set_data), .data_out(gap_len_reg)
    );
    setting_reg #(.ADDR(8'(BASE + REG_NO_GAP_SYM))) u_no_gap (
        .clk(clk), .reset(reset), .strobe(set_stb), .addr(set_addr),
        .data_in(set_data), .data_out(no_gap_reg)
    );

    always_comb begin
        cfg_fl        = clamp_len({1'b0, frame_len_reg}, MAX_LEN);
        cfg_gl        = ({1'b0, gap_len_reg} > cfg_fl) ? cfg_fl : {1'b0, gap_len_reg};
        cfg_fl_m1     = cfg_fl - 17'd1;
        cfg_gap_start = cfg_fl - cfg_gl;
    end
    assign unused_cfg = ^{cfg_fl_m1[16:AWIDTH], cfg_gap_start[16:AWIDTH]};

    // Live settings apply on the first beat of a symbol, latched copies thereafter
    assign first_beat    = (wr_addr == '0);
    assign eff_fl_m1     = first_beat ? cfg_fl_m1[AWIDTH-1:0]     : lat_fl_m1;
    assign eff_gap_start = first_beat ? cfg_gap_start[AWIDTH-1:0] : lat_gap_start;
    assign eff_gap_zero  = first_beat ? (cfg_gl == 17'd0)         : lat_gap_zero;
    assign eff_no_gap    = first_beat ? no_gap_reg                : lat_no_gap;

    assign in_fire   = (state == ST_LOAD) && stream_i_tvalid;
    assign load_done = in_fire && (wr_addr == eff_fl_m1);
    assign skip_gap  = eff_gap_zero || (sym_idx == eff_no_gap);
    assign playing   = (state == ST_GAP) || (state == ST_FRAME);
    assign advance   = !o_valid || stream_o_tready;
    assign rd_end    = (rd_addr == lat_fl_m1);

    always_ff @(posedge clk) begin
        if (reset || clear)
            state <= ST_LOAD;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD:  if (load_done) state_next = skip_gap ? ST_FRAME : ST_GAP;
            ST_GAP:   if (advance && rd_end) state_next = ST_FRAME;
            ST_FRAME: if (advance && rd_end) state_next = ST_LOAD;
            default:  state_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_addr  <= '0;
            rd_addr  <= '0;
            sym_idx  <= 16'd1;
            last_sym <= 1'b0;
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
            o_eob    <= 1'b0;
        end else begin
            if (in_fire) begin
                wr_addr <= wr_addr + 1'b1;
                if (first_beat) begin
                    lat_fl_m1     <= eff_fl_m1;
                    lat_gap_start <= eff_gap_start;
                    lat_gap_zero  <= eff_gap_zero;
                    lat_no_gap    <= eff_no_gap;
                end
                if (load_done) begin
                    wr_addr  <= '0;
                    last_sym <= stream_i_tlast;
                    rd_addr  <= skip_gap ? '0 : eff_gap_start;
                end
            end
            if (advance) begin
                if (playing) begin
                    o_valid <= 1'b1;
                    o_last  <= (state == ST_FRAME) && rd_end;
                    o_eob   <= last_sym;
                    if (rd_end) begin
                        rd_addr <= '0;
                        if (state == ST_FRAME)
                            sym_idx <= last_sym ? 16'd1 : sym_idx + 16'd1;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end else begin
                    o_valid <= 1'b0;
                    o_last  <= 1'b0;
                    o_eob   <= 1'b0;
                end
            end
        end
    end

    ram_2port #(.DWIDTH(WIDTH), .AWIDTH(AWIDTH)) u_ram (
        .clka(clk), .ena(1'b1), .wea(in_fire), .addra(wr_addr), .dia(stream_i_tdata),
        .clkb(clk), .enb(advance && playing), .addrb(rd_addr), .dob(stream_o_tdata)
    );

    assign stream_i_tready = (state == ST_LOAD);
    assign stream_o_tvalid = o_valid;
    assign stream_o_tlast  = o_last;
    assign eob             = o_eob;

endmodule

// File: tb/tb_periodic_gap_inserter.sv
// tb/tb_periodic_gap_inserter.sv - scoreboard bench for periodic_gap_inserter
module tb_periodic_gap_inserter;

    localparam int WIDTH  = 32;
    localparam int AWIDTH = 11;
    localparam int MAXLEN = 1 << AWIDTH;

    logic clk = 1'b0;
    logic reset, clear, set_stb;
    logic [7:0] set_addr;
    logic [31:0] set_data;
    logic [WIDTH-1:0] i_tdata, o_tdata;
    logic i_tlast, i_tvalid, i_tready;
    logic o_tlast, o_tvalid, o_tready;
    logic eob;

    always #5 clk = ~clk;

    periodic_gap_inserter #(.BASE(0), .WIDTH(WIDTH), .AWIDTH(AWIDTH)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .stream_i_tdata(i_tdata), .stream_i_tlast(i_tlast),
        .stream_i_tvalid(i_tvalid), .stream_i_tready(i_tready),
        .stream_o_tdata(o_tdata), .stream_o_tlast(o_tlast),
        .stream_o_tvalid(o_tvalid), .stream_o_tready(o_tready),
        .eob(eob)
    );

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        e;
    } exp_t;

    exp_t exq[$];
    logic [31:0] cur_sym[$];
    int total = 0;
    int bad = 0;
    int s_fl = 0, s_gl = 0, s_ngs = 0, m_idx = 1;
    bit rand_ready = 0, rand_valid = 0;
    bit stall_prev = 0;
    logic [31:0] prev_d;
    logic prev_l;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int clamp_fl(input int v);
        return (v == 0) ? 1 : ((v > MAXLEN) ? MAXLEN : v);
    endfunction

    // Reference: prefix = last gl samples, then whole symbol; skip prefix on the no-gap index
    task automatic model_symbol(input bit last);
        int fl = clamp_fl(s_fl);
        int gl = (s_gl > fl) ? fl : s_gl;
        if (gl != 0 && m_idx != s_ngs)
            for (int k = fl - gl; k < fl; k++) exq.push_back('{cur_sym[k], 1'b0, last});
        for (int k = 0; k < fl; k++) exq.push_back('{cur_sym[k], k == fl - 1, last});
        m_idx = last ? 1 : m_idx + 1;
    endtask

    initial begin
        o_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            o_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset || clear) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", o_tvalid, 1);
                check("hold_data", o_tdata, prev_d);
                check("hold_last", o_tlast, prev_l);
            end
            if (o_tvalid && o_tready) begin
                if (exq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got data %0h, want no beat", o_tdata);
                end else begin
                    e = exq.pop_front();
                    check("out_data", o_tdata, e.d);
                    check("out_last", o_tlast, e.l);
                    check("out_eob", eob, e.e);
                end
            end
            if (i_tready && o_tvalid) check("no_overlap", o_tlast, 1);
            stall_prev = o_tvalid && !o_tready;
            prev_d = o_tdata;
            prev_l = o_tlast;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [7:0] a, input int v);
        set_stb = 1'b1;
        set_addr = a;
        set_data = 32'(v);
        tick();
        set_stb = 1'b0;
    endtask

    task automatic configure(input int fl, input int gl, input int ngs);
        write_reg(8'd0, fl);
        write_reg(8'd1, gl);
        write_reg(8'd2, ngs);
        s_fl = fl;
        s_gl = gl;
        s_ngs = ngs;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        int n = 0;
        bit ok = 0;
        if (rand_valid)
            while ($urandom_range(0, 2) == 0) tick();
        i_tdata = d;
        i_tlast = l;
        i_tvalid = 1'b1;
        while (!ok && n < 3000) begin
            @(negedge clk);
            ok = i_tready;
            @(posedge clk);
            #1;
            n++;
        end
        i_tvalid = 1'b0;
        i_tlast = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL in_accept: got no tready in %0d cycles, want acceptance", n);
        end
    endtask

    task automatic send_symbol(input bit last, input bit ramp);
        int fl = clamp_fl(s_fl);
        logic noise;
        cur_sym.delete();
        for (int k = 0; k < fl; k++) cur_sym.push_back(ramp ? 32'(k) : $urandom);
        for (int k = 0; k < fl; k++) begin
            noise = rand_valid ? 1'($urandom_range(0, 1)) : 1'b0;
            send_beat(cur_sym[k], (k == fl - 1) ? last : noise);
        end
        model_symbol(last);
    endtask

    task automatic drain();
        int n = 0;
        while ((exq.size() != 0 || o_tvalid) && n < 6000) begin
            tick();
            n++;
        end
        if (n >= 6000) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d beats outstanding, want 0", exq.size());
        end
        exq.delete();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_valid", o_tvalid, 0);
        check("clr_iready", i_tready, 1);
        check("clr_eob", eob, 0);
        exq.delete();
        m_idx = 1;
    endtask

    initial begin
        int n;
        reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
        i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_valid", o_tvalid, 0);
        check("rst_last", o_tlast, 0);
        check("rst_eob", eob, 0);
        check("rst_iready", i_tready, 1);

        configure(8, 2, 0);
        send_symbol(1, 1);
        check("lat_first", o_tvalid, 0);
        tick();
        check("lat_second", o_tvalid, 1);
        check("play_iready", i_tready, 0);
        drain();

        configure(4, 0, 0);
        send_symbol(0, 0);
        send_symbol(1, 0);
        drain();

        configure(64, 16, 2);
        send_symbol(0, 0);
        send_symbol(0, 0);
        send_symbol(1, 0);
        drain();

        rand_ready = 1;
        rand_valid = 1;
        configure(16, 4, 0);
        for (int s = 0; s < 4; s++) send_symbol(1'($urandom_range(0, 1)), 0);
        drain();

        configure(0, 3, 0);
        send_symbol(0, 0);
        send_symbol(1, 0);
        drain();
        configure(4, 10, 0);
        send_symbol(1, 0);
        drain();

        rand_ready = 0;
        rand_valid = 0;
        configure(8, 2, 0);
        for (int k = 0; k < 3; k++) send_beat(32'hA000 + 32'(k), 1'b0);
        pulse_clear();
        send_symbol(0, 1);
        n = 0;
        while (exq.size() > 6 && n < 200) begin
            tick();
            n++;
        end
        check("mid_play_reached", 64'(exq.size() <= 6), 1);
        pulse_clear();
        send_symbol(1, 0);
        drain();

        rand_ready = 1;
        rand_valid = 1;
        for (int r = 0; r < 6; r++) begin
            configure(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24),
                      $urandom_range(0, 30), $urandom_range(0, 3));
            for (int s = 0; s < 3; s++) send_symbol(1'($urandom_range(0, 1)), 0);
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
